ifetch: RTL

Instruction fetch stage placed directly upstream of the instruction `rom`. It owns the program counter, drives the ROM address, and pairs each synchronous ROM read result with its PC. It delivers (pc, instr) pairs to decode over a valid/ready handshake, and supports single-cycle redirects from execute (branches and jumps). With decode always ready it sustains one instruction per cycle, and it never loses or duplicates an instruction under backpressure.

---
 rtl/core_pkg.sv | 9 +
 rtl/fetch_skid.sv | 63 ++++++
 rtl/ifetch.sv | 91 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core constants: datapath width, default reset PC and the NOP encoding.
package core_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    // addi x0, x0, 0
    localparam logic [31:0] NOP      = 32'h0000_0013;

endpackage

// File: rtl/fetch_skid.sv
// One-entry pc/instr skid buffer. Captures a ROM response that decode did not
// take so the ROM can be re-pointed without losing the word. A flush (redirect)
// empties it. hold_next_valid tells the top whether the buffer will be occupied
// next cycle, which is what gates the next ROM read.
module fetch_skid
    import core_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         flush,
    input  logic         fire,
    input  logic         resp_valid,
    input  logic [W-1:0] resp_pc,
    input  logic [W-1:0] resp_instr,
    output logic         hold_valid,
    output logic [W-1:0] hold_pc,
    output logic [W-1:0] hold_instr,
    output logic         hold_next_valid
);

    logic [W-1:0] hold_next_pc;
    logic [W-1:0] hold_next_instr;

    // Next buffer contents: keep an unconsumed held entry, otherwise capture an
    // unconsumed response; a flush drops everything.
    always_comb begin
        hold_next_valid = 1'b0;
        hold_next_pc    = hold_pc;
        hold_next_instr = hold_instr;
        if (flush) begin
            hold_next_valid = 1'b0;
        end else if (hold_valid) begin
            if (!fire) begin
                hold_next_valid = 1'b1;
            end else if (resp_valid) begin
                // The held entry was the one presented, so the response is still pending.
                hold_next_valid = 1'b1;
                hold_next_pc    = resp_pc;
                hold_next_instr = resp_instr;
            end
        end else if (resp_valid && !fire) begin
            hold_next_valid = 1'b1;
            hold_next_pc    = resp_pc;
            hold_next_instr = resp_instr;
        end
    end

    // Buffer registers; payload clears on reset so outputs read zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_pc    <= '0;
            hold_instr <= '0;
        end else begin
            hold_valid <= hold_next_valid;
            hold_pc    <= hold_next_pc;
            hold_instr <= hold_next_instr;
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage in front of a synchronous-read ROM. Owns the PC,
// pairs each ROM word with the PC that fetched it and hands (pc, instr) to
// decode. Redirects from execute take effect in the cycle they are raised.
//
// Handshake: an instruction transfers in a cycle where out_valid and out_ready
// are both high. While out_valid is high and out_ready low, out_pc/out_instr
// hold steady; only a redirect may withdraw a presented instruction.
module ifetch #(
    parameter int              XLEN     = core_pkg::XLEN,
    parameter int              MEMSIZE  = 32 * 1024,
    parameter logic [XLEN-1:0] RESET_PC = core_pkg::RESET_PC,
    localparam int             AW       = $clog2(MEMSIZE)
) (
    input  logic            clock,
    input  logic            reset,
    output logic [AW-1:0]   rom_addr,
    input  logic [XLEN-1:0] rom_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    logic [XLEN-1:0] fetch_pc;
    logic            resp_valid;
    logic [XLEN-1:0] resp_pc;
    logic            hold_valid;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;
    logic            hold_next_valid;
    logic [XLEN-1:0] issue_pc;
    logic            issue;
    logic            fire;

    // Word-aligned redirect target wins over the sequential PC.
    assign issue_pc = redirect_valid ? (redirect_pc & ~XLEN'(3)) : fetch_pc;
    // A redirect always empties the skid buffer, so it always issues too.
    assign issue    = ~hold_next_valid;
    // When not issuing, issue_pc equals fetch_pc and the re-read is ignored.
    assign rom_addr = issue_pc[AW-1:0];

    assign out_valid = (hold_valid | resp_valid) & ~redirect_valid;
    assign fire      = out_valid & out_ready;

    // Present the held entry first, else the live ROM response, else zeros.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (hold_valid) begin
            out_pc    = hold_pc;
            out_instr = hold_instr;
        end else if (resp_valid) begin
            out_pc    = resp_pc;
            out_instr = rom_data;
        end
    end

    // PC and in-flight read tracking.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc   <= RESET_PC;
            resp_valid <= 1'b0;
            resp_pc    <= '0;
        end else if (issue) begin
            fetch_pc   <= issue_pc + XLEN'(4);
            resp_valid <= 1'b1;
            resp_pc    <= issue_pc;
        end else begin
            resp_valid <= 1'b0;
        end
    end

    fetch_skid #(
        .W (XLEN)
    ) u_skid (
        .clock           (clock),
        .reset           (reset),
        .flush           (redirect_valid),
        .fire            (fire),
        .resp_valid      (resp_valid),
        .resp_pc         (resp_pc),
        .resp_instr      (rom_data),
        .hold_valid      (hold_valid),
        .hold_pc         (hold_pc),
        .hold_instr      (hold_instr),
        .hold_next_valid (hold_next_valid)
    );

endmodule
